// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage of the 32-point SDF FFT: captures bit-reversed frames into
// a ping-pong buffer and replays each one gap-free in natural bin order.
module fft_bitrev_reorder #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int WIDTH = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] data_real_in,
  input  logic signed [WIDTH-1:0] data_imag_in,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] data_real_out,
  output logic signed [WIDTH-1:0] data_imag_out,
  output logic [LOG2N-1:0]        out_index,
  output logic                    out_last
);

  typedef enum logic {IDLE, PLAY} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // Bank select is the address MSB: entries 0..N-1 are bank A, N..2N-1 bank B.
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic [1:0]       full;

  state_t           state, state_next;
  logic             rd_bank, rd_bank_next;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_next;

  logic             wr_done;
  logic             play_done;
  logic             other_ready;

  logic             out_valid_d;
  logic             out_last_d;
  logic [LOG2N-1:0] out_index_d;
  logic [2*WIDTH-1:0] rd_word;

  assign wr_done   = in_valid && (wr_cnt == LOG2N'(N-1));
  assign play_done = (state == PLAY) && (rd_cnt == LOG2N'(N-1));
  // The other bank counts as ready if it is already full or fills on this very edge.
  assign other_ready = full[~rd_bank] || (wr_done && (wr_bank == ~rd_bank));

  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      mem[{wr_bank, bitrev(wr_cnt)}] <= {data_real_in, data_imag_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      wr_cnt <= wr_cnt + LOG2N'(1);
      if (wr_done) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (play_done) begin
        full[rd_bank] <= 1'b0;
      end
      if (wr_done) begin
        full[wr_bank] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state   <= state_next;
      rd_bank <= rd_bank_next;
      rd_cnt  <= rd_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    rd_bank_next = rd_bank;
    rd_cnt_next  = rd_cnt;
    case (state)
      IDLE: begin
        if (wr_done) begin
          state_next   = PLAY;
          rd_bank_next = wr_bank;
          rd_cnt_next  = '0;
        end
      end
      PLAY: begin
        rd_cnt_next = rd_cnt + LOG2N'(1);
        if (play_done) begin
          if (other_ready) begin
            rd_bank_next = ~rd_bank;
          end else begin
            state_next  = IDLE;
            rd_cnt_next = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_index_d = '0;
    rd_word     = '0;
    if (state == PLAY) begin
      out_valid_d = 1'b1;
      out_last_d  = play_done;
      out_index_d = rd_cnt;
      rd_word     = mem[{rd_bank, rd_cnt}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_index     <= '0;
      data_real_out <= '0;
      data_imag_out <= '0;
    end else begin
      out_valid     <= out_valid_d;
      out_last      <= out_last_d;
      out_index     <= out_index_d;
      data_real_out <= rd_word[2*WIDTH-1:WIDTH];
      data_imag_out <= rd_word[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: frames are issued in bit-reversed order and
// a monitor checks natural-order output, exact cycle of each bin, and idle zeros.
module tb_fft_bitrev_reorder;
  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int WIDTH = 22;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic signed [WIDTH-1:0] data_real_in = '0;
  logic signed [WIDTH-1:0] data_imag_in = '0;
  logic                    out_valid;
  logic signed [WIDTH-1:0] data_real_out;
  logic signed [WIDTH-1:0] data_imag_out;
  logic [LOG2N-1:0]        out_index;
  logic                    out_last;

  fft_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .data_real_in(data_real_in),
    .data_imag_in(data_imag_in),
    .out_valid(out_valid),
    .data_real_out(data_real_out),
    .data_imag_out(data_imag_out),
    .out_index(out_index),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                      cyc;
    logic [LOG2N-1:0]        idx;
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
    logic                    last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   run_len = 0;
  int   last_run = 0;
  int   valid_seen = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every valid output must match the queue head at its predicted cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      run_len++;
      valid_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got index %0d, want no output", out_index);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("out_cycle", edge_cnt, mon_e.cyc);
        checkOutput("out_index", out_index, mon_e.idx);
        checkOutput("data_real", data_real_out, mon_e.re);
        checkOutput("data_imag", data_imag_out, mon_e.im);
        checkOutput("out_last", out_last, mon_e.last);
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      checkOutput("idle_zero", {out_valid, out_last, out_index, data_real_out, data_imag_out}, 64'd0);
      if (exp_q.size() != 0 && exp_q[0].cyc <= edge_cnt) begin
        total++;
        bad++;
        $display("[TB] FAIL missing_output: got none, want index %0d at cycle %0d", exp_q[0].idx, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // Drive one frame; sample k carries bin bitrev(k) with value re_base+bin / im_base+im_scale*bin.
  task automatic applyStimulus(input int re_base, input int im_base, input int im_scale, input int gap_pct);
    logic [LOG2N-1:0] b;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      b = bitrev5(LOG2N'(k));
      in_valid     = 1'b1;
      data_real_in = WIDTH'(re_base + int'(b));
      data_imag_in = WIDTH'(im_base + im_scale * int'(b));
      if (k == N-1) begin
        for (int j = 0; j < N; j++) begin
          e.cyc  = edge_cnt + 2 + j;
          e.idx  = LOG2N'(j);
          e.re   = WIDTH'(re_base + j);
          e.im   = WIDTH'(im_base + im_scale * j);
          e.last = (j == N-1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input int budget);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      @(negedge clk);
      in_valid = 1'b0;
      cnt++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic applyReset(input int cycles, input bit keep_valid);
    @(negedge clk);
    rst = 1'b1;
    if (!keep_valid) in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    checkOutput("reset_outputs", {out_valid, out_last, out_index, data_real_out, data_imag_out}, 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int v0;
    int guard;
    $display("[TB] reset test");
    in_valid     = 1'b1;
    data_real_in = 22'sd12345;
    data_imag_in = -22'sd777;
    applyReset(2, 1'b1);
    v0 = valid_seen;
    idle(40);
    checkOutput("no_valid_after_reset", valid_seen - v0, 0);

    $display("[TB] single frame");
    applyStimulus(0, 0, -1, 0);
    waitDrain(80);
    idle(3);
    checkOutput("single_run_len", last_run, 32);

    $display("[TB] back-to-back frames");
    applyStimulus(0, 5, -3, 0);
    applyStimulus(100, 105, -3, 0);
    applyStimulus(200, 205, -3, 0);
    waitDrain(120);
    idle(3);
    checkOutput("b2b_run_len", last_run, 96);

    $display("[TB] gapped frame");
    applyStimulus(-2097152, 2097151, -1, 50);
    waitDrain(80);
    idle(2);

    $display("[TB] mid-frame reset");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid     = 1'b1;
      data_real_in = 22'sd999;
      data_imag_in = 22'sd999;
    end
    applyReset(1, 1'b0);
    applyStimulus(500, -40, 7, 0);
    waitDrain(80);
    idle(2);

    $display("[TB] mid-playback reset");
    applyStimulus(3000, -3000, 2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!(out_valid === 1'b1 && out_index == 5'd10) && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reached_index10", guard < 80, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    checkOutput("valid_after_midplay_reset", out_valid, 1'b0);
    rst = 1'b0;
    idle(3);
    applyStimulus(-1000, 1000, -5, 0);
    waitDrain(80);
    idle(3);
    checkOutput("fresh_run_len", last_run, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
